// File: rtl/ser_operand_seq.sv
// Bit-serial operand sequencer: streams two 32-bit operands LSB first into an
// external serial adder, then reassembles the registered sum and final carry.
module ser_operand_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic        o_a,
  output logic        o_b,
  output logic        o_clr,
  input  logic        i_q,
  input  logic        i_cy,
  output logic [31:0] o_result,
  output logic        o_carry,
  output logic        o_done
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  res;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          last_bit;

  assign last_bit = (cnt == CW'(W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state; adder-side bits only while shifting
  always_comb begin
    o_ready = 1'b0;
    o_a     = 1'b0;
    o_b     = 1'b0;
    o_clr   = 1'b0;
    o_done  = 1'b0;
    case (state)
      IDLE:  o_ready = 1'b1;
      SHIFT: begin
        o_a   = sa[0];
        o_b   = sb[0];
        o_clr = (cnt == '0);
      end
      DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: the adder's sum lags by one cycle, so the first SHIFT cycle
  // captures nothing and DRAIN takes the final (32nd) bit with the carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sa  <= i_op_a;
            sb  <= i_op_b;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa <= {1'b0, sa[W-1:1]};
          sb <= {1'b0, sb[W-1:1]};
          if (cnt != '0) res <= {i_q, res[W-1:1]};
          if (!last_bit) cnt <= cnt + CW'(1);
        end
        DRAIN: begin
          res   <= {i_q, res[W-1:1]};
          carry <= i_cy;
        end
        default: ;
      endcase
    end
  end

  assign o_result = res;
  assign o_carry  = carry;

endmodule

// File: tb/tb_ser_operand_seq.sv
// Bench for ser_operand_seq paired with a registered serial full adder;
// results are checked against plain 33-bit addition of the operands.
module tb_ser_operand_seq;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        o_a;
  logic        o_b;
  logic        o_clr;
  logic        i_q;
  logic        i_cy;
  logic [31:0] o_result;
  logic        o_carry;
  logic        o_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    int          mode;
  } vec_t;

  vec_t vecs[7];

  ser_operand_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .o_a      (o_a),
    .o_b      (o_b),
    .o_clr    (o_clr),
    .i_q      (i_q),
    .i_cy     (i_cy),
    .o_result (o_result),
    .o_carry  (o_carry),
    .o_done   (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conforming serial adder: registered sum and carry, carry-in cleared by o_clr
  always @(posedge clk) begin
    if (!rst_n) begin
      i_q  <= 1'b0;
      i_cy <= 1'b0;
    end else begin
      i_q  <= o_a ^ o_b ^ (i_cy & ~o_clr);
      i_cy <= (o_a & o_b) | ((o_a ^ o_b) & i_cy & ~o_clr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One operation from an idle cycle through T+35.
  // mode: 0 = i_valid low while busy, 1 = held high, 2 = random pulses.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input int mode,
                        input logic [31:0] na, input logic [31:0] nb);
    chk("ready_before_accept", 33'(o_ready), 33'(1));
    i_valid = 1'b1;
    i_op_a  = a;
    i_op_b  = b;
    step();
    i_op_a  = na;
    i_op_b  = nb;
    i_valid = (mode == 1);
    for (int k = 1; k <= 35; k++) begin
      chk("ready", 33'(o_ready), 33'(k == 35));
      chk("done", 33'(o_done), 33'(k == 34));
      chk("clr", 33'(o_clr), 33'(k == 1));
      if (k <= 32) begin
        chk("serial_a", 33'(o_a), 33'(a[k-1]));
        chk("serial_b", 33'(o_b), 33'(b[k-1]));
      end else begin
        chk("serial_idle", {31'd0, o_a, o_b}, 33'(0));
      end
      if (k >= 34) begin
        chk("result", 33'(o_result), 33'(er));
        chk("carry", 33'(o_carry), 33'(ec));
      end
      if (k < 35) begin
        if (mode == 2) i_valid = 1'($urandom);
        step();
      end
    end
    if (mode != 1) i_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] sum;

    vecs[0] = '{32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 0};
    vecs[2] = '{32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 2};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2};
    vecs[4] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 2};
    vecs[6] = '{32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 0};

    // Reset with i_valid asserted: must come up idle and clear
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_op_a  = 32'hDEADBEEF;
    i_op_b  = 32'h12345678;
    step();
    step();
    chk("rst_ready", 33'(o_ready), 33'(1));
    chk("rst_result", 33'(o_result), 33'(0));
    chk("rst_carry", 33'(o_carry), 33'(0));
    chk("rst_done", 33'(o_done), 33'(0));
    chk("rst_serial", {30'd0, o_a, o_b, o_clr}, 33'(0));
    rst_n   = 1'b1;
    i_valid = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].mode,
             $urandom, $urandom);

    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      sum = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, sum[31:0], sum[32], int'($urandom_range(0, 2)) & 2,
             $urandom, $urandom);
    end

    // i_valid held high across two pairs: second accept exactly 35 cycles later
    run_op(32'h00000005, 32'h00000007, 32'h0000000C, 1'b0, 1,
           32'hF0000000, 32'h20000000);
    run_op(32'hF0000000, 32'h20000000, 32'h10000000, 1'b1, 0,
           32'h0, 32'h0);

    // Reset at cnt=10 of a new operation aborts it with no done pulse
    step();
    i_valid = 1'b1;
    i_op_a  = 32'h0000_0400;
    i_op_b  = 32'h0000_0000;
    step();
    i_valid = 1'b0;
    for (int k = 1; k < 11; k++) step();
    chk("mid_clr", 33'(o_clr), 33'(0));
    chk("mid_bit10", 33'(o_a), 33'(1));
    chk("mid_ready", 33'(o_ready), 33'(0));
    rst_n   = 1'b0;
    i_valid = 1'b1;
    step();
    chk("abort_ready", 33'(o_ready), 33'(1));
    chk("abort_result", 33'(o_result), 33'(0));
    chk("abort_carry", 33'(o_carry), 33'(0));
    chk("abort_serial", {30'd0, o_a, o_b, o_clr}, 33'(0));
    rst_n   = 1'b1;
    i_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      chk("abort_no_done", 33'(o_done), 33'(0));
      chk("abort_idle", 33'(o_ready), 33'(1));
      step();
    end

    sum = {1'b0, 32'h7FFFFFFF} + {1'b0, 32'h00000001};
    run_op(32'h7FFFFFFF, 32'h00000001, sum[31:0], sum[32], 0, 32'h1, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
